// File: rtl/spu_reg_player_pkg.sv
// Shared definitions for the SPU register player: opcodes, bus addresses,
// the legal register window and the player state encoding.
package spu_reg_player_pkg;

    // Op byte values that are commands rather than register addresses
    localparam logic [7:0] OP_WAIT = 8'h00;
    localparam logic [7:0] OP_POLL = 8'h01;
    localparam logic [7:0] OP_END  = 8'hFF;

    // CPU-side view of the SPU register page
    localparam logic [15:0] SPU_PAGE_BASE = 16'hFF00;
    localparam logic [15:0] ADDR_NR52     = 16'hFF26;

    // Register windows a plain write may target: FF10-FF26 and wave RAM FF30-FF3F
    localparam logic [7:0] WR_LO_A = 8'h10;
    localparam logic [7:0] WR_HI_A = 8'h26;
    localparam logic [7:0] WR_LO_B = 8'h30;
    localparam logic [7:0] WR_HI_B = 8'h3F;

    // Shared tick counter: wide enough for 256 WAIT ticks and 1023 POLL ticks
    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT,
        RD,
        CHK,
        PWAIT,
        OFF,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        CMD_WRITE,
        CMD_WAIT,
        CMD_POLL,
        CMD_END,
        CMD_ILLEGAL
    } cmd_kind_e;

    // True when the op byte names a register the player may write
    function automatic logic is_reg_addr(input logic [7:0] op);
        return ((op >= WR_LO_A) && (op <= WR_HI_A)) ||
               ((op >= WR_LO_B) && (op <= WR_HI_B));
    endfunction

    // Classify an op byte into the command it represents
    function automatic cmd_kind_e decode_op(input logic [7:0] op);
        cmd_kind_e kind;
        if (op == OP_WAIT) begin
            kind = CMD_WAIT;
        end else if (op == OP_POLL) begin
            kind = CMD_POLL;
        end else if (op == OP_END) begin
            kind = CMD_END;
        end else if (is_reg_addr(op)) begin
            kind = CMD_WRITE;
        end else begin
            kind = CMD_ILLEGAL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/spu_reg_player.sv
// SPU register player: consumes 16-bit commands and replays them onto the
// CPU-side SPU register bus as single-cycle write/read strobes, with
// tick-timed waits, NR52 status polling and a halt/resume point.
// Optional build macro SPU_PLAYER_MUTE_ON_HALT_EN: when defined, END first
// writes FF26=00 (powering the SPU off) before entering HALT.
module spu_reg_player
    import spu_reg_player_pkg::*;
#(
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic        tick,
    input  logic        resume,
    output logic [15:0] spu_addr,
    output logic [7:0]  spu_data,
    output logic        spu_read,
    output logic        spu_write,
    input  logic [7:0]  spu_bus_out,
    input  logic        spu_bus_oe,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    // Poll gives up on the tick that would take the counter to POLL_MAX
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);

    state_e           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       dat_q, dat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    cmd_kind_e        cmd_kind;
    logic             poll_busy;

    assign cmd_kind  = decode_op(cmd_data[15:8]);
    assign poll_busy = (spu_bus_out & {4'h0, dat_q[3:0]}) != 8'h00;
    assign err       = err_q;

    // State register; reset abandons whatever command was in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command bytes, shared tick counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= 8'h00;
            dat_q <= 8'h00;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Next-state logic: command decode on accept, tick counting, poll checks
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_data[15:8];
                    dat_d = cmd_data[7:0];
                    case (cmd_kind)
                        CMD_WRITE: begin
                            state_d = WR;
                        end
                        CMD_WAIT: begin
                            cnt_d   = {2'b00, cmd_data[7:0]};
                            state_d = WAIT;
                        end
                        CMD_POLL: begin
                            cnt_d   = '0;
                            state_d = RD;
                        end
                        CMD_END: begin
`ifdef SPU_PLAYER_MUTE_ON_HALT_EN
                            state_d = OFF;
`else
                            state_d = HALT;
`endif
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            RD: begin
                state_d = CHK;
            end
            CHK: begin
                if (!spu_bus_oe) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!poll_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = PWAIT;
                end
            end
            PWAIT: begin
                if (tick) begin
                    if (cnt_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = RD;
                    end
                end
            end
            OFF: begin
                state_d = HALT;
            end
            HALT: begin
                if (resume) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded purely from state so strobes last one cycle
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        spu_read  = 1'b0;
        spu_write = 1'b0;
        spu_addr  = 16'h0000;
        spu_data  = 8'h00;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            WR: begin
                spu_write = 1'b1;
                spu_addr  = SPU_PAGE_BASE | {8'h00, op_q};
                spu_data  = dat_q;
            end
            RD: begin
                spu_read = 1'b1;
                spu_addr = ADDR_NR52;
            end
            OFF: begin
                spu_write = 1'b1;
                spu_addr  = ADDR_NR52;
                spu_data  = 8'h00;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spu_reg_player.sv
// Testbench for spu_reg_player: drives commands, models the SPU's NR52 read
// port and a divided tick, and compares bus strobes against a scoreboard of
// expected transactions tagged with the cycle they must appear in.
module tb_spu_reg_player;

    localparam int unsigned POLL_MAX_TB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_data = 16'h0000;
    logic        tick = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] spu_addr;
    logic [7:0]  spu_data;
    logic        spu_read;
    logic        spu_write;
    logic [7:0]  spu_bus_out = 8'h00;
    logic        spu_bus_oe = 1'b0;
    logic        busy;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       oe_en = 1'b1;
    logic [7:0] nr52_val = 8'h00;
    logic       tick_en = 1'b0;
    int         tick_div = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    spu_reg_player #(.POLL_MAX(POLL_MAX_TB)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .tick        (tick),
        .resume      (resume),
        .spu_addr    (spu_addr),
        .spu_data    (spu_data),
        .spu_read    (spu_read),
        .spu_write   (spu_write),
        .spu_bus_out (spu_bus_out),
        .spu_bus_oe  (spu_bus_oe),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: one-cycle pulse every 10 cycles while enabled
    always @(posedge clk) begin
        tick_div <= (tick_div == 9) ? 0 : tick_div + 1;
        tick     <= tick_en && (tick_div == 9);
    end

    // SPU read port model: NR52 value returned the cycle after spu_read
    always @(posedge clk) begin
        spu_bus_oe  <= spu_read && oe_en;
        spu_bus_out <= spu_read ? nr52_val : 8'h00;
    end

    // Bus monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (spu_read || spu_write) begin
                checks++;
                if (spu_read && spu_write) begin
                    errors++;
                    $display("[TB] FAIL strobe_overlap: read=%b write=%b, required one-hot", spu_read, spu_write);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: cyc=%0d wr=%b addr=%h data=%h, required no strobe",
                             cyc, spu_write, spu_addr, spu_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({spu_write, spu_addr, spu_data} !== {e.wr, e.addr, e.data} || cyc != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL bus_txn: got wr=%b addr=%h data=%h cyc=%0d, expected wr=%b addr=%h data=%h cyc=%0d",
                                 spu_write, spu_addr, spu_data, cyc, e.wr, e.addr, e.data, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (spu_addr !== 16'h0000 || spu_data !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL idle_bus: addr=%h data=%h, expected 0000/00", spu_addr, spu_data);
                end
            end
        end
    end

    function automatic logic [29:0] pack_outputs();
        return {cmd_ready, busy, halted, err, spu_read, spu_write, spu_addr, spu_data};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        resume    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Present a command (caller is at posedge+1) and return the accept cycle
    task automatic send_cmd(input logic [15:0] c, input bit hold, output int n);
        cmd_data  = c;
        cmd_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            errors++;
            $display("[TB] FAIL accept_timeout: cmd %h not accepted, expected acceptance", c);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_data  = 16'h0000;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (pack_outputs() !== {1'b1, 29'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h, expected %h", pack_outputs(), {1'b1, 29'd0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        int n;
        do_reset();
        send_cmd(16'h1277, 1'b0, n);
        exp_q.push_back('{1'b1, 16'hFF12, 8'h77, n + 1});
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_busy: ready/busy=%b, expected 01", {cmd_ready, busy});
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_done: ready/busy=%b, expected 10", {cmd_ready, busy});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL write_missing: %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] cmds[3] = '{16'h2680, 16'h3012, 16'h14C3};
        int n;
        int n0;
        do_reset();
        n0 = 0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(cmds[i], (i < 2), n);
            if (i == 0) n0 = n;
            exp_q.push_back('{1'b1, {8'hFF, cmds[i][15:8]}, cmds[i][7:0], n0 + 1 + 2 * i});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_missing: %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        logic [7:0] bad[6]  = '{8'h02, 8'h0F, 8'h27, 8'h2F, 8'h40, 8'hFE};
        logic [7:0] good[4] = '{8'h10, 8'h26, 8'h30, 8'h3F};
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_cmd({good[i], good[i] ^ 8'h5A}, 1'b0, n);
            exp_q.push_back('{1'b1, {8'hFF, good[i]}, good[i] ^ 8'h5A, n + 1});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL legal_edges: err=%b pending=%0d, expected 0/0", err, exp_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            do_reset();
            send_cmd({bad[i], 8'h12}, 1'b0, n);
            @(negedge clk);
            checks++;
            if ({err, cmd_ready, busy} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL illegal_%h: err/ready/busy=%b, expected 110", bad[i], {err, cmd_ready, busy});
            end
        end
        do_reset();
        send_cmd(16'h4012, 1'b0, n);
        send_cmd(16'h2A00, 1'b0, n);
        send_cmd(16'h1F55, 1'b0, n);
        exp_q.push_back('{1'b1, 16'hFF1F, 8'h55, n + 1});
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL illegal_then_legal: err=%b pending=%0d, expected 1/0", err, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wait();
        logic [7:0] dvals[3] = '{8'h00, 8'h03, 8'hFF};
        int n;
        int ticks;
        int last;
        int rdy;
        do_reset();
        tick_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_cmd({8'h00, dvals[k]}, 1'b0, n);
            ticks = 0;
            last  = -1;
            rdy   = -1;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    rdy = cyc;
                    break;
                end
                if (tick) begin
                    ticks++;
                    last = cyc;
                end
            end
            checks++;
            if (ticks != int'(dvals[k]) + 1 || rdy != last + 1) begin
                errors++;
                $display("[TB] FAIL wait_%h: ticks=%0d ready_cyc=%0d, expected ticks=%0d ready_cyc=%0d",
                         dvals[k], ticks, rdy, int'(dvals[k]) + 1, last + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_poll();
        int n;
        int t;
        int last;
        int done;
        do_reset();
        oe_en    = 1'b1;
        nr52_val = 8'hF1;
        send_cmd(16'h0100, 1'b0, n);
        exp_q.push_back('{1'b0, 16'hFF26, 8'h00, n + 1});
        done = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = cyc;
                break;
            end
        end
        checks++;
        if (done != n + 3 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL poll_mask0: done=%0d err=%b, expected done=%0d err=0", done, err, n + 3);
        end
        tick_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) break;
        end
        @(posedge clk);
        #1;
        send_cmd(16'h0101, 1'b0, n);
        exp_q.push_back('{1'b0, 16'hFF26, 8'h00, n + 1});
        t = 0;
        last = -1;
        done = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = cyc;
                break;
            end
            if (tick) begin
                t++;
                last = cyc;
                exp_q.push_back('{1'b0, 16'hFF26, 8'h00, cyc + 1});
                if (t == 3) nr52_val = 8'hF0;
            end
        end
        checks++;
        if (t != 3 || done != last + 3 || err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL poll_done: ticks=%0d done=%0d err=%b pending=%0d, expected 3/%0d/0/0",
                     t, done, err, exp_q.size(), last + 3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_poll_timeout();
        int n;
        int t;
        int last;
        int done;
        do_reset();
        oe_en    = 1'b1;
        nr52_val = 8'hF1;
        tick_en  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) break;
        end
        @(posedge clk);
        #1;
        send_cmd(16'h0101, 1'b0, n);
        exp_q.push_back('{1'b0, 16'hFF26, 8'h00, n + 1});
        t = 0;
        last = -1;
        done = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = cyc;
                break;
            end
            if (tick) begin
                t++;
                last = cyc;
                if (t < int'(POLL_MAX_TB)) exp_q.push_back('{1'b0, 16'hFF26, 8'h00, cyc + 1});
            end
        end
        checks++;
        if (t != int'(POLL_MAX_TB) || done != last + 1 || err !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL poll_timeout: ticks=%0d done=%0d err=%b pending=%0d, expected %0d/%0d/1/0",
                     t, done, err, exp_q.size(), POLL_MAX_TB, last + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_poll_no_oe();
        int n;
        int done;
        do_reset();
        oe_en    = 1'b0;
        nr52_val = 8'hF1;
        send_cmd(16'h0101, 1'b0, n);
        exp_q.push_back('{1'b0, 16'hFF26, 8'h00, n + 1});
        done = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = cyc;
                break;
            end
        end
        checks++;
        if (done != n + 3 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL poll_no_oe: done=%0d err=%b, expected done=%0d err=1", done, err, n + 3);
        end
        oe_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_halt();
        int n;
        int hc;
        int hexp;
        int r;
        do_reset();
        send_cmd(16'hFF00, 1'b0, n);
`ifdef SPU_PLAYER_MUTE_ON_HALT_EN
        exp_q.push_back('{1'b1, 16'hFF26, 8'h00, n + 1});
        hexp = n + 2;
`else
        hexp = n + 1;
`endif
        hc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted) begin
                hc = cyc;
                break;
            end
        end
        checks++;
        if (hc != hexp || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_entry: cyc=%0d ready=%b, expected cyc=%0d ready=0", hc, cmd_ready, hexp);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h1234;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({halted, cmd_ready} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL halt_hold: halted/ready=%b, expected 10", {halted, cmd_ready});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        resume    = 1'b1;
        r         = cyc;
        @(posedge clk);
        #1;
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, cmd_ready, busy} !== 3'b010 || cyc != r + 1) begin
            errors++;
            $display("[TB] FAIL resume: halted/ready/busy=%b cyc=%0d, expected 010 cyc=%0d",
                     {halted, cmd_ready, busy}, cyc, r + 1);
        end
        @(posedge clk);
        #1;
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, cmd_ready, busy} !== 3'b010 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL resume_idle: halted/ready/busy=%b pending=%0d, expected 010/0",
                     {halted, cmd_ready, busy}, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset();
        send_cmd(16'h4400, 1'b0, n);
        tick_en = 1'b1;
        send_cmd(16'h0040, 1'b0, n);
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pre_reset: busy/err=%b, expected 11", {busy, err});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pack_outputs() !== {1'b1, 29'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait: got %h, expected %h", pack_outputs(), {1'b1, 29'd0});
        end
        repeat (30) @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: ready/busy=%b, expected 10", {cmd_ready, busy});
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_illegal();
        test_wait();
        test_poll();
        test_poll_timeout();
        test_poll_no_oe();
        test_halt();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck design cannot hang the run
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
